m2vside_queue: RTL and testbench
================================

# m2vside_queue

Multi-entry side-information queue that replaces the single-register third-stage container between the block-side-info stage (s2) and the reconstruction stage (s3). It buffers up to DEPTH per-block records (motion vector, macroblock position, intra flag, block index, coded, enable) so the parser can run ahead of reconstruction. It uses an explicit push/pop handshake with full, valid and level status. Field widths and depth are parameters.

## Interface
Parameters:
- MVH_WIDTH, 16, horizontal motion vector width
- MVV_WIDTH, 15, vertical motion vector width
- MBX_WIDTH, 6, macroblock X index width
- MBY_WIDTH, 5, macroblock Y index width
- DEPTH, 4, number of entries; power of two, 2..64
- LW, $clog2(DEPTH)+1, width of `level`

Ports:
- clk  in  1  clock
- reset_n  in  1  reset; asynchronous, active-low
- s2_mv_h  in  MVH_WIDTH  incoming horizontal MV
- s2_mv_v  in  MVV_WIDTH  incoming vertical MV
- s2_mb_x  in  MBX_WIDTH  incoming macroblock X
- s2_mb_y  in  MBY_WIDTH  incoming macroblock Y
- s2_mb_intra  in  1  incoming intra flag
- s2_block  in  3  incoming block index 0..5
- s2_coded  in  1  incoming coded flag
- s2_enable  in  1  incoming enable flag
- push  in  1  one-cycle pulse (block_start from the parser); writes one record
- pop  in  1  one-cycle pulse from the consumer; releases the head record
- s3_mv_h, s3_mv_v, s3_mb_x, s3_mb_y, s3_mb_intra, s3_block, s3_coded  out  as s2_*  head record fields
- s3_enable  out  1  head enable, gated with s3_valid
- s3_valid  out  1  queue non-empty
- full  out  1  level == DEPTH
- level  out  LW  number of stored records, 0..DEPTH
- err  out  1  sticky protocol error; present only with M2VSIDE_ERR_EN

## Operation
- Circular buffer in flops with write pointer wp, read pointer rp (each log2(DEPTH) bits) and counter `level`. Pointers wrap modulo DEPTH.
- Push is accepted when `!full || pop`. An accepted push stores the s2_* fields at wp and increments wp.
- Pop is accepted when `s3_valid`. An accepted pop increments rp.
- Level update:
  - accepted push only: level+1
  - accepted pop only: level-1
  - both accepted: level unchanged
- Push when full, with pop asserted: both are accepted; the head leaves and the new record enters the freed slot.
- Push when full, without pop: the record is dropped and the stored contents are unchanged.
- Pop when empty: ignored. With push asserted in the same cycle, the push is accepted and level becomes 1. There is no same-cycle bypass.
- Head fields s3_* are driven from the entry at rp.
- When empty, s3_valid=0 and s3_enable=0. The other s3_* fields hold the value of the last head entry; they are don't-care to the consumer.
- Records leave in strict FIFO order. No field is modified.

## Timing
- Reset (asynchronous assert; release synchronous to clk): wp=rp=0, level=0, all storage entries 0, all outputs 0, err=0.
- Push at edge N into an empty queue: s3_valid=1 and the head fields are valid in cycle N+1. Write-to-read latency is one cycle, matching the previous single-latch stage.
- Pop at edge N: the next head (or s3_valid=0) appears in cycle N+1.
- full and level are registered and update one cycle after the causing edge.
- Reset mid-operation: all content is discarded immediately. No partial record survives.
- push and pop are sampled only at the rising edge. A multi-cycle pulse counts once per cycle.

## Configuration
- M2VSIDE_ERR_EN defined:
  - `err` port exists.
  - err is set at the edge of a dropped push (full without pop) or an ignored pop (empty without push).
  - err is cleared only by reset.
- M2VSIDE_ERR_EN undefined:
  - `err` port and its logic are absent.
  - Dropped pushes and ignored pops are silent.
  - Queue behaviour is otherwise identical.

## Structure
- Shared package m2v_side_pkg holds:
  - default field-width constants
  - the record width constant SIDE_W = MVH+MVV+MBX+MBY+1+3+1+1
  - pack/unpack field offsets, reused by later stages
- One sub-module, m2vside_qmem: DEPTH x SIDE_W flop array with asynchronous reset, write port (we, waddr, wdata) and combinational read port (raddr, rdata).
- Pointer, level and error logic live in m2vside_queue.

## Test plan
- Reset then idle → s3_valid=0, full=0, level=0, all s3_* = 0.
- Push record A (mv_h=16'h1234, mb_x=5, block=3, enable=1) at cycle 0 → cycle 1: s3_valid=1, s3_mv_h=16'h1234, s3_block=3, level=1. Pop at cycle 2 → cycle 3: s3_valid=0, s3_enable=0.
- Push 4 distinct records with DEPTH=4 → full=1, level=4. A 5th push without pop is dropped and err=1 under the macro. Four pops return records 1..4 in order.
- Queue full, push and pop in the same cycle → level stays 4. The head advances to record 2, and the new record is read out last.
- Queue empty, push and pop in the same cycle → level=1, and the pushed record is at the head next cycle. Pop-only when empty → no change; err=1 under the macro.
- Fill to 3 entries, assert reset_n low mid-cycle → outputs 0 immediately. After release, wrap-around over 2*DEPTH push/pop pairs preserves FIFO order.

Source files
------------

// File: rtl/m2v_side_pkg.sv
// m2v_side_pkg: shared definitions for the s2 -> s3 side-information path.
// Holds the default field widths, the packed record width SIDE_W and the
// field offsets inside a packed record. Records are packed MSB-first as
//   {mv_h, mv_v, mb_x, mb_y, mb_intra, block[2:0], coded, enable}
// so enable is bit 0.
package m2v_side_pkg;

  localparam int MVH_W_DEF = 16;
  localparam int MVV_W_DEF = 15;
  localparam int MBX_W_DEF = 6;
  localparam int MBY_W_DEF = 5;

  // Record width for arbitrary field widths: 4 variable fields plus
  // intra(1) + block(3) + coded(1) + enable(1).
  function automatic int side_w(input int mvh, input int mvv,
                                input int mbx, input int mby);
    return mvh + mvv + mbx + mby + 6;
  endfunction

  localparam int SIDE_W = side_w(MVH_W_DEF, MVV_W_DEF, MBX_W_DEF, MBY_W_DEF);

  localparam int OFS_ENABLE = 0;
  localparam int OFS_CODED  = 1;
  localparam int OFS_BLOCK  = 2;
  localparam int OFS_INTRA  = 5;
  localparam int OFS_MBY    = 6;
  localparam int OFS_MBX    = OFS_MBY + MBY_W_DEF;
  localparam int OFS_MVV    = OFS_MBX + MBX_W_DEF;
  localparam int OFS_MVH    = OFS_MVV + MVV_W_DEF;

  // Per-cycle queue operation, encoded as {push accepted, pop accepted}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } q_op_e;

endpackage

// File: rtl/m2vside_qmem.sv
// m2vside_qmem: DEPTH x W flop storage for the side-information queue.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset (clears all entries)
//   we, waddr, wdata : synchronous write port
//   raddr, rdata     : combinational read port
module m2vside_qmem #(
  parameter int DEPTH = 4,
  parameter int W     = 48,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/m2vside_queue.sv
// m2vside_queue: multi-entry side-information FIFO between the block
// side-info stage (s2) and reconstruction (s3).
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   s2_*                : incoming record fields, written on an accepted push
//   push, pop           : one-cycle handshake pulses, sampled at rising edge
//   s3_*                : head record fields (s3_enable gated with s3_valid)
//   s3_valid, full      : queue non-empty / queue holds DEPTH records
//   level               : number of stored records, 0..DEPTH
//   err                 : sticky protocol error, only when M2VSIDE_ERR_EN is
//                         defined (dropped push or ignored pop)
module m2vside_queue
  import m2v_side_pkg::*;
#(
  parameter int MVH_WIDTH = MVH_W_DEF,
  parameter int MVV_WIDTH = MVV_W_DEF,
  parameter int MBX_WIDTH = MBX_W_DEF,
  parameter int MBY_WIDTH = MBY_W_DEF,
  parameter int DEPTH     = 4,
  parameter int LW        = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [MVH_WIDTH-1:0] s2_mv_h,
  input  logic [MVV_WIDTH-1:0] s2_mv_v,
  input  logic [MBX_WIDTH-1:0] s2_mb_x,
  input  logic [MBY_WIDTH-1:0] s2_mb_y,
  input  logic                 s2_mb_intra,
  input  logic [2:0]           s2_block,
  input  logic                 s2_coded,
  input  logic                 s2_enable,
  input  logic                 push,
  input  logic                 pop,
  output logic [MVH_WIDTH-1:0] s3_mv_h,
  output logic [MVV_WIDTH-1:0] s3_mv_v,
  output logic [MBX_WIDTH-1:0] s3_mb_x,
  output logic [MBY_WIDTH-1:0] s3_mb_y,
  output logic                 s3_mb_intra,
  output logic [2:0]           s3_block,
  output logic                 s3_coded,
  output logic                 s3_enable,
  output logic                 s3_valid,
  output logic                 full,
  output logic [LW-1:0]        level
`ifdef M2VSIDE_ERR_EN
  ,
  output logic                 err
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int RW = side_w(MVH_WIDTH, MVV_WIDTH, MBX_WIDTH, MBY_WIDTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [LW-1:0] level_q, level_d;
  logic          full_q, full_d;
  logic          push_ok, pop_ok;
  q_op_e         op;
  logic [RW-1:0] wr_data, rd_data;
  logic          head_enable;

  // A full queue still takes a push when the head leaves in the same cycle.
  assign push_ok = push && (!full_q || pop);
  assign pop_ok  = pop && (level_q != '0);
  assign op      = q_op_e'({push_ok, pop_ok});

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    level_d = level_q;
    if (push_ok) wp_d = wp_q + PTR_ONE;
    if (pop_ok)  rp_d = rp_q + PTR_ONE;
    unique case (op)
      OP_PUSH: level_d = level_q + LVL_ONE;
      OP_POP:  level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
    full_d = (level_d == LVL_FULL);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      level_q <= level_d;
      full_q  <= full_d;
    end
  end

`ifdef M2VSIDE_ERR_EN
  logic err_q, err_d;

  // A pop on an empty queue is only an error when no push rides along.
  always_comb begin
    err_d = err_q;
    if ((push && !push_ok) || (pop && (level_q == '0) && !push)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign err = err_q;
`endif

  assign wr_data = {s2_mv_h, s2_mv_v, s2_mb_x, s2_mb_y,
                    s2_mb_intra, s2_block, s2_coded, s2_enable};

  m2vside_qmem #(
    .DEPTH (DEPTH),
    .W     (RW),
    .AW    (PW)
  ) u_qmem (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (push_ok),
    .waddr   (wp_q),
    .wdata   (wr_data),
    .raddr   (rp_q),
    .rdata   (rd_data)
  );

  assign {s3_mv_h, s3_mv_v, s3_mb_x, s3_mb_y,
          s3_mb_intra, s3_block, s3_coded, head_enable} = rd_data;

  assign s3_valid  = (level_q != '0);
  assign s3_enable = head_enable & s3_valid;
  assign full      = full_q;
  assign level     = level_q;

endmodule

// File: tb/tb_m2vside_queue.sv
module tb_m2vside_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [15:0] mv_h;
    logic [14:0] mv_v;
    logic [5:0]  mb_x;
    logic [4:0]  mb_y;
    logic        intra;
    logic [2:0]  block;
    logic        coded;
    logic        enable;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        push = 1'b0, pop = 1'b0;
  rec_t        din = '0;
  logic [15:0] s3_mv_h;
  logic [14:0] s3_mv_v;
  logic [5:0]  s3_mb_x;
  logic [4:0]  s3_mb_y;
  logic        s3_mb_intra, s3_coded, s3_enable, s3_valid, full;
  logic [2:0]  s3_block;
  logic [2:0]  level;
`ifdef M2VSIDE_ERR_EN
  logic        err;
`endif

  rec_t sb[$];
  logic err_exp = 1'b0;
  int   n_vec = 0;
  int   n_mis = 0;

  always #5 clk = ~clk;

  m2vside_queue #(
    .MVH_WIDTH (16),
    .MVV_WIDTH (15),
    .MBX_WIDTH (6),
    .MBY_WIDTH (5),
    .DEPTH     (DEPTH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .s2_mv_h     (din.mv_h),
    .s2_mv_v     (din.mv_v),
    .s2_mb_x     (din.mb_x),
    .s2_mb_y     (din.mb_y),
    .s2_mb_intra (din.intra),
    .s2_block    (din.block),
    .s2_coded    (din.coded),
    .s2_enable   (din.enable),
    .push        (push),
    .pop         (pop),
    .s3_mv_h     (s3_mv_h),
    .s3_mv_v     (s3_mv_v),
    .s3_mb_x     (s3_mb_x),
    .s3_mb_y     (s3_mb_y),
    .s3_mb_intra (s3_mb_intra),
    .s3_block    (s3_block),
    .s3_coded    (s3_coded),
    .s3_enable   (s3_enable),
    .s3_valid    (s3_valid),
    .full        (full),
    .level       (level)
`ifdef M2VSIDE_ERR_EN
    ,
    .err         (err)
`endif
  );

  rec_t head_obs;
  assign head_obs = '{mv_h: s3_mv_h, mv_v: s3_mv_v, mb_x: s3_mb_x,
                      mb_y: s3_mb_y, intra: s3_mb_intra, block: s3_block,
                      coded: s3_coded, enable: s3_enable};

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every status output and, when non-empty, the head record
  // against the scoreboard front.
  task automatic check_state(input string tag);
    logic [2:0] exp_lvl;
    exp_lvl = 3'(sb.size());
    chk({tag, ".valid"}, 64'(s3_valid), 64'(sb.size() != 0));
    chk({tag, ".level"}, 64'(level), 64'(exp_lvl));
    chk({tag, ".full"},  64'(full),  64'(sb.size() == DEPTH));
    if (sb.size() != 0) chk({tag, ".head"}, 64'(head_obs), 64'(sb[0]));
    else                chk({tag, ".en0"}, 64'(s3_enable), 64'd0);
`ifdef M2VSIDE_ERR_EN
    chk({tag, ".err"}, 64'(err), 64'(err_exp));
`endif
  endtask

  task automatic step(input logic p, input logic q, input rec_t r,
                      input string tag);
    logic acc_push, acc_pop;
    @(negedge clk);
    push = p;
    pop  = q;
    din  = r;
    acc_pop  = q && (sb.size() != 0);
    acc_push = p && ((sb.size() < DEPTH) || q);
    if ((p && !acc_push) || (q && (sb.size() == 0) && !p)) err_exp = 1'b1;
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
    if (acc_pop)  void'(sb.pop_front());
    if (acc_push) sb.push_back(r);
    check_state(tag);
  endtask

  function automatic rec_t mk(input int unsigned k);
    rec_t r;
    r = rec_t'({$urandom, $urandom});
    r.mv_h  = 16'(16'hA000 + k);
    r.block = 3'(k % 6);
    return r;
  endfunction

  initial begin
    rec_t a, z;
    z = '0;

    // Reset state.
    #12;
    check_state("rst");
    chk("rst.head_zero", 64'(head_obs), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, 1'b0, z, "idle");

    // Single record A: one-cycle write-to-read latency.
    a = '0;
    a.mv_h = 16'h1234; a.mb_x = 6'd5; a.block = 3'd3; a.enable = 1'b1;
    step(1'b1, 1'b0, a, "pushA");
    chk("pushA.mv_h", 64'(s3_mv_h), 64'h1234);
    step(1'b0, 1'b0, z, "holdA");
    step(1'b0, 1'b1, z, "popA");
    chk("popA.enable", 64'(s3_enable), 64'd0);

    // Fill, drop on full, drain in order.
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, mk(i), "fill");
    chk("fill.full", 64'(full), 64'd1);
    step(1'b1, 1'b0, mk(99), "drop");
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, z, "drain");

    // Full with simultaneous push and pop.
    for (int i = 11; i <= 14; i++) step(1'b1, 1'b0, mk(i), "fill2");
    step(1'b1, 1'b1, mk(15), "fullboth");
    chk("fullboth.head", 64'(s3_mv_h), 64'(16'hA000 + 12));
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, z, "drain2");

    // Empty with simultaneous push and pop, then pop-only on empty.
    step(1'b1, 1'b1, mk(20), "emptyboth");
    chk("emptyboth.level", 64'(level), 64'd1);
    step(1'b0, 1'b1, z, "drain3");
    step(1'b0, 1'b1, z, "popempty");

    // Asynchronous reset mid-cycle with 3 records stored.
    for (int i = 30; i < 33; i++) step(1'b1, 1'b0, mk(i), "fill3");
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    sb.delete();
    err_exp = 1'b0;
    check_state("arst");
    chk("arst.head_zero", 64'(head_obs), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Pointer wrap-around with push/pop pairs.
    step(1'b1, 1'b0, mk(40), "wrap0");
    for (int i = 41; i < 41 + 2 * DEPTH; i++) step(1'b1, 1'b1, mk(i), "wrap");
    step(1'b0, 1'b1, z, "wrapend");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule
